// File: rtl/uart_engine.sv
// uart_engine: full-duplex UART with a shared 16x oversample tick generator.
//
// TX state  | meaning
// IDLE      | line high, tx_ready asserted, waiting for tx_valid
// START     | start bit (0) for 16 ticks
// DATA      | data bits, LSB first, 16 ticks each
// PARITY    | parity bit, only when parity is enabled
// STOP      | one or two stop bits (1)
//
// RX state  | meaning
// IDLE      | waiting for sync_rx to go low
// START     | confirm the start bit at its mid-point (tick 8)
// DATA      | sample data bits every 16 ticks
// PARITY    | sample parity bit
// STOP      | sample stop bit and deliver (or drop) the word
// WAIT_HIGH | stop bit was low (break); wait for the line to go high
module uart_engine #(
    parameter int DATA_W = 8,
    parameter int DIV_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DIV_W-1:0]  clk_div,
    input  logic [1:0]        parity_mode,
    input  logic              stop2,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic [DATA_W-1:0] tx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_parity_err,
    output logic              rx_frame_err,
    output logic              rx_overrun,
    input  logic              rx,
    output logic              tx
);
    localparam logic [3:0] BIT_LAST = 4'(DATA_W - 1);

    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HIGH
    } rx_state_t;

    logic [DIV_W-1:0]  div_cnt;
    logic              tick;

    tx_state_t         tx_state;
    logic [DATA_W-1:0] tx_sh;
    logic [3:0]        tx_ph;
    logic [3:0]        tx_bit;
    logic              tx_par;
    logic              tx_par_en;
    logic              tx_stop2;
    logic              tx_stop_2nd;

    logic [1:0]        rx_sync;
    logic              sync_rx;
    rx_state_t         rx_state;
    logic [DATA_W-1:0] rx_sh;
    logic [3:0]        rx_ph;
    logic [3:0]        rx_bit;
    logic              rx_par_en;
    logic              rx_odd;
    logic              rx_par_bit;
    logic              rx_samp;

    // >= rather than == so a clk_div lowered below the current count wraps at once
    assign tick    = (div_cnt >= clk_div);
    assign sync_rx = rx_sync[1];
    // START samples at the 8th tick (mid-bit); every later sample is 16 ticks on
    assign rx_samp = tick && (rx_ph == ((rx_state == RX_START) ? 4'd7 : 4'd15));

    // Free-running oversample divider: counts 0..clk_div, tick at wrap
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)  div_cnt <= '0;
        else if (tick) div_cnt <= '0;
        else           div_cnt <= div_cnt + DIV_W'(1);
    end

    // TX FSM: accept on handshake, then shift out start/data/parity/stop bits
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_state    <= TX_IDLE;
            tx          <= 1'b1;
            tx_ready    <= 1'b0;
            tx_sh       <= '0;
            tx_ph       <= '0;
            tx_bit      <= '0;
            tx_par      <= 1'b0;
            tx_par_en   <= 1'b0;
            tx_stop2    <= 1'b0;
            tx_stop_2nd <= 1'b0;
        end else if (tx_state == TX_IDLE) begin
            tx_ready <= 1'b1;
            tx       <= 1'b1;
            if (tx_valid && tx_ready) begin
                tx_sh       <= tx_data;
                tx_par      <= (^tx_data) ^ (parity_mode == 2'b10);
                tx_par_en   <= (parity_mode == 2'b01) || (parity_mode == 2'b10);
                tx_stop2    <= stop2;
                tx_stop_2nd <= 1'b0;
                tx_ph       <= '0;
                tx_bit      <= '0;
                tx          <= 1'b0;
                tx_ready    <= 1'b0;
                tx_state    <= TX_START;
            end
        end else if (tick) begin
            if (tx_ph != 4'd15) begin
                tx_ph <= tx_ph + 4'd1;
            end else begin
                tx_ph <= '0;
                case (tx_state)
                    TX_START: begin
                        tx       <= tx_sh[0];
                        tx_state <= TX_DATA;
                    end
                    TX_DATA: begin
                        tx_sh <= tx_sh >> 1;
                        if (tx_bit == BIT_LAST) begin
                            if (tx_par_en) begin
                                tx       <= tx_par;
                                tx_state <= TX_PARITY;
                            end else begin
                                tx       <= 1'b1;
                                tx_state <= TX_STOP;
                            end
                        end else begin
                            tx     <= tx_sh[1];
                            tx_bit <= tx_bit + 4'd1;
                        end
                    end
                    TX_PARITY: begin
                        tx       <= 1'b1;
                        tx_state <= TX_STOP;
                    end
                    TX_STOP: begin
                        if (tx_stop2 && !tx_stop_2nd) begin
                            tx_stop_2nd <= 1'b1;
                        end else begin
                            tx_state <= TX_IDLE;
                            tx_ready <= 1'b1;
                        end
                    end
                    default: tx_state <= TX_IDLE;
                endcase
            end
        end
    end

    // Two-flop synchroniser for the asynchronous serial input, idles high
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rx_sync <= 2'b11;
        else          rx_sync <= {rx_sync[0], rx};
    end

    // RX FSM plus the held-word registers and their handshake/overrun handling
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_state      <= RX_IDLE;
            rx_sh         <= '0;
            rx_ph         <= '0;
            rx_bit        <= '0;
            rx_par_en     <= 1'b0;
            rx_odd        <= 1'b0;
            rx_par_bit    <= 1'b0;
            rx_valid      <= 1'b0;
            rx_data       <= '0;
            rx_parity_err <= 1'b0;
            rx_frame_err  <= 1'b0;
            rx_overrun    <= 1'b0;
        end else begin
            if (rx_valid && rx_ready) begin
                rx_valid      <= 1'b0;
                rx_overrun    <= 1'b0;
                rx_parity_err <= 1'b0;
                rx_frame_err  <= 1'b0;
            end
            if (tick)    rx_ph <= rx_ph + 4'd1;
            if (rx_samp) rx_ph <= '0;
            case (rx_state)
                RX_IDLE: begin
                    if (!sync_rx) begin
                        rx_state  <= RX_START;
                        rx_ph     <= '0;
                        rx_bit    <= '0;
                        rx_par_en <= (parity_mode == 2'b01) || (parity_mode == 2'b10);
                        rx_odd    <= (parity_mode == 2'b10);
                    end
                end
                RX_START: begin
                    if (rx_samp) rx_state <= sync_rx ? RX_IDLE : RX_DATA;
                end
                RX_DATA: begin
                    if (rx_samp) begin
                        rx_sh  <= {sync_rx, rx_sh[DATA_W-1:1]};
                        rx_bit <= rx_bit + 4'd1;
                        if (rx_bit == BIT_LAST) rx_state <= rx_par_en ? RX_PARITY : RX_STOP;
                    end
                end
                RX_PARITY: begin
                    if (rx_samp) begin
                        rx_par_bit <= sync_rx;
                        rx_state   <= RX_STOP;
                    end
                end
                RX_STOP: begin
                    if (rx_samp) begin
                        // a handshake on this same edge frees the holding register
                        if (!rx_valid || rx_ready) begin
                            rx_valid      <= 1'b1;
                            rx_data       <= rx_sh;
                            rx_parity_err <= rx_par_en && (rx_par_bit != ((^rx_sh) ^ rx_odd));
                            rx_frame_err  <= !sync_rx;
                        end else begin
                            rx_overrun <= 1'b1;
                        end
                        rx_state <= sync_rx ? RX_IDLE : RX_WAIT_HIGH;
                    end
                end
                RX_WAIT_HIGH: begin
                    if (sync_rx) rx_state <= RX_IDLE;
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end
endmodule

// File: doc/uart_engine.md
UART_ENGINE -- requirements
Module: uart_engine

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning data bits per frame; legal range 5..9.
REQ-002 SHALL have parameter DIV_W, default 16, meaning width of the baud divisor.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic SHALL be in this domain, with no derived clocks.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port clk_div, input, DIV_W bits: a 16x oversample tick fires every clk_div+1 clk cycles.
REQ-006 SHALL have port parity_mode, input, 2 bits: 00 none, 01 even, 10 odd; 11 SHALL behave as none.
REQ-007 SHALL have port stop2, input, 1 bit: 1 = TX sends two stop bits.
REQ-008 SHALL have port tx_valid, input, 1 bit: TX data offered.
REQ-009 SHALL have port tx_ready, output, 1 bit: TX can accept a word.
REQ-010 SHALL have port tx_data, input, DATA_W bits: word to send.
REQ-011 SHALL have port rx_valid, output, 1 bit: received word held.
REQ-012 SHALL have port rx_ready, input, 1 bit: consumer accepts the held word.
REQ-013 SHALL have port rx_data, output, DATA_W bits: received word.
REQ-014 SHALL have port rx_parity_err, output, 1 bit: parity mismatch on the held word.
REQ-015 SHALL have port rx_frame_err, output, 1 bit: stop bit sampled low on the held word.
REQ-016 SHALL have port rx_overrun, output, 1 bit: at least one frame was dropped while rx_valid was high.
REQ-017 SHALL have port rx, input, 1 bit: serial line in, asynchronous to clk.
REQ-018 SHALL have port tx, output, 1 bit: serial line out, registered.

Function
REQ-019 SHALL implement the tick generator as a free-running counter 0..clk_div that pulses tick for one cycle at wrap; clk_div=0 SHALL give a tick every cycle.
REQ-020 SHALL define one bit period as 16 ticks; clk_div changes SHALL be applied only while TX and RX are both idle, and mid-frame behaviour is unchecked.
REQ-021 SHALL use a TX FSM with states IDLE, START, DATA, PARITY, STOP, with tx_ready=1 only in IDLE.
REQ-022 SHALL accept a TX word on clk edge where tx_valid&&tx_ready; at that edge tx_data, parity_mode and stop2 SHALL be latched, the FSM SHALL go to START, and tx SHALL be driven 0.
REQ-023 SHALL hold each TX bit for 16 ticks; with clk_div=0 this is exactly 16 clk cycles.
REQ-024 SHALL send data LSB first; the PARITY state SHALL be entered only if parity is enabled; even parity = XOR of data bits, odd parity = its inverse.
REQ-025 SHALL send 1 or 2 stop bits (value 1) per latched stop2, then go to IDLE, with tx_ready=1 on the following cycle; tx_valid held high SHALL start the next frame back-to-back.
REQ-026 SHALL synchronise rx through a 2-flop synchroniser reset to 1; the synchronised value is sync_rx.
REQ-027 SHALL use an RX FSM with states IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
REQ-028 In RX IDLE, sync_rx=0 SHALL go to START and clear the tick phase.
REQ-029 In RX START, the line SHALL be sampled at tick 8; if high, the FSM SHALL return to IDLE (false start), with no output change.
REQ-030 SHALL sample data, parity and stop bits every 16 ticks after the mid-start sample, assembled LSB first.
REQ-031 SHALL check exactly one stop bit regardless of stop2.
REQ-032 On the stop-bit sample with rx_valid=0: next cycle rx_data, rx_parity_err and rx_frame_err SHALL be loaded and rx_valid=1.
REQ-033 On the stop-bit sample with rx_valid=1: the new frame SHALL be discarded, the held word SHALL remain unchanged, and rx_overrun SHALL be set.
REQ-034 rx_valid, rx_overrun and the error flags SHALL clear on the cycle after rx_valid&&rx_ready.
REQ-035 If the completing frame's handshake coincides with the stop sample, the new frame SHALL load and no overrun SHALL be flagged.
REQ-036 If the stop bit is sampled low, the frame SHALL be delivered with rx_frame_err=1 and the FSM SHALL go to WAIT_HIGH, returning to IDLE only when sync_rx=1; this is break handling.
REQ-037 RX parity_mode SHALL be sampled at the start bit.
REQ-038 TX and RX SHALL be fully independent; simultaneous activity is legal.

Reset
REQ-039 While reset_n=0: tx=1, tx_ready=0, rx_valid=0, rx_data=0, all error flags 0, sync flops=1, both FSMs in IDLE, tick counter 0.
REQ-040 SHALL assert tx_ready=1 on the first clk edge after reset_n deasserts.
REQ-041 Reset mid-frame SHALL abort both frames immediately, with tx=1 and no partial word delivered.

Verification
REQ-042 clk_div=0, DATA_W=8, parity none, stop2=0, send 0x55 -> tx: 16 clk low, then 1,0,1,0,1,0,1,0 each 16 clk, then 16 clk high; tx_ready returns 160 clk after accept.
REQ-043 Loopback tx->rx, clk_div=3, parity even, send 0xA3 -> parity bit 0, rx_data=0xA3, rx_valid=1, all error flags 0.
REQ-044 Drive an rx frame 0x3C with stop bit 0, then line high -> rx_data=0x3C, rx_frame_err=1; the next valid frame is received without error.
REQ-045 rx_ready=0, two frames 0x11 then 0x22 -> rx_data stays 0x11, rx_overrun=1; after one handshake rx_valid=0 and rx_overrun=0.
REQ-046 clk_div=0, rx low for 5 clk then high -> no rx_valid, RX back in IDLE; a following frame 0x81 is received correctly.
REQ-047 Assert reset_n=0 mid-TX (DATA state) -> tx=1 asynchronously; tx_ready=1 one clk edge after release; no rx_valid.
